multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the team's 8-bit microprocessor datapath: PC, instruction memory, 4x8 register file, ALU, data memory.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath write strobes and mux selects.
- Advances only on `step_en` pulses from the clock divider, so progress stays visible on the PC/instruction/result seven-segment displays.
- Also counts retired instructions and supports a clean halt at an instruction boundary.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/ctrl_decode.sv | 53 +++++
 rtl/multicycle_ctrl.sv | 115 +++++++++++
 tb/tb_multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU.
// The datapath, the control sequencer and the display decoder all use this package.
// Contents:
//   - opcode constants, taken from instr[7:6]
//   - controller state encodings, also shown on the debug display
//   - PC mux select codes
//   - ctrl_t: the bundle of datapath strobes and mux selects
//   - is_retire(): tells whether a state/opcode pair is the last step of an instruction
package cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_JMP = 2'b01;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       rf_we;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_re;
        logic       mem_we;
        logic       mem_to_reg;
    } ctrl_t;

    // Each instruction retires in its final state:
    //   JMP in DECODE, SW in MEM, ADD and LW in WB.
    function automatic logic is_retire(input logic [2:0] st, input logic [1:0] op);
        return ((st == S_DECODE) && (op == OP_JMP)) ||
               ((st == S_MEM)    && (op == OP_SW))  ||
               (st == S_WB);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decoder for the multi-cycle controller.
// Ports:
//   state   in   current controller state
//   opcode  in   opcode latched during FETCH
//   step_en in   advance pulse; every write strobe is qualified by it
//   ctrl    out  datapath strobes and mux selects
// Mux selects are Moore outputs, decoded from state and opcode only.
// Write strobes are additionally ANDed with step_en.
// As a result, each write happens exactly once per state, however long
// the controller waits in that state between step pulses.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0] state,
    input  logic [1:0] opcode,
    input  logic       step_en,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_we  = step_en;
                ctrl.pc_we  = step_en;
                ctrl.pc_src = PC_SRC_INC;
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    ctrl.pc_we  = step_en;
                    ctrl.pc_src = PC_SRC_JMP;
                end
            end
            S_EXEC: begin
                ctrl.alu_src = (opcode != OP_ADD);
            end
            S_MEM: begin
                ctrl.alu_src = 1'b1;
                ctrl.mem_re  = (opcode == OP_LW);
                ctrl.mem_we  = (opcode == OP_SW) && step_en;
            end
            S_WB: begin
                ctrl.rf_we      = step_en;
                ctrl.reg_dst    = (opcode == OP_ADD);
                ctrl.mem_to_reg = (opcode == OP_LW);
                // Keep the memory read enabled so its data is stable for write-back.
                ctrl.mem_re     = (opcode == OP_LW);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the 8-bit CPU datapath.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB.
// The controller moves to the next step only on step_en pulses.
// It also counts retired instructions and can halt cleanly at an
// instruction boundary.
// Ports:
//   clk, Reset          clock; synchronous active-high reset
//   step_en             advance pulse from the clock divider
//   instr               instruction memory data at the current PC
//   halt_req            level; stop once the current instruction retires
//   ir_we .. mem_to_reg datapath strobes and mux selects
//   state               current state (registered), for the display
//   instr_done          combinational pulse on the retiring step
//   retired             retired-instruction count (registered, wraps)
//   halted              controller is in HALT (registered)
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int OP_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             step_en,
    input  logic [7:0]       instr,
    input  logic             halt_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [OP_W-1:0]  opcode_q;
    logic [CNT_W-1:0] retired_q;
    logic             halted_q;
    logic             retire;
    logic [2:0]       done_target;
    ctrl_t            ctrl;
    ctrl_t            ctrl_g;

    ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opcode_q),
        .step_en (step_en),
        .ctrl    (ctrl)
    );

    assign retire      = is_retire(state_q, opcode_q) && step_en && !Reset;
    assign done_target = halt_req ? S_HALT : S_FETCH;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (step_en) state_d = S_DECODE;
            S_DECODE: if (step_en) state_d = (opcode_q == OP_JMP) ? done_target : S_EXEC;
            S_EXEC:   if (step_en) state_d = (opcode_q == OP_ADD) ? S_WB : S_MEM;
            S_MEM: begin
                if (step_en) begin
                    if (opcode_q == OP_LW)      state_d = S_WB;
                    else if (opcode_q == OP_SW) state_d = done_target;
                    else                        state_d = S_FETCH;
                end
            end
            S_WB:     if (step_en) state_d = done_target;
            S_HALT:   if (step_en && !halt_req) state_d = S_FETCH;
            // Unused codes recover to FETCH without waiting for a step.
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALT);
            if ((state_q == S_FETCH) && step_en)
                opcode_q <= instr[7 -: OP_W];
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Reset overrides the decoder, so nothing is written while Reset is held.
    assign ctrl_g = Reset ? '0 : ctrl;

    assign ir_we      = ctrl_g.ir_we;
    assign pc_we      = ctrl_g.pc_we;
    assign pc_src     = ctrl_g.pc_src;
    assign rf_we      = ctrl_g.rf_we;
    assign reg_dst    = ctrl_g.reg_dst;
    assign alu_src    = ctrl_g.alu_src;
    assign mem_re     = ctrl_g.mem_re;
    assign mem_we     = ctrl_g.mem_we;
    assign mem_to_reg = ctrl_g.mem_to_reg;
    assign state      = state_q;
    assign instr_done = retire;
    assign retired    = retired_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Expected values are written out by hand at each step.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_en;
    logic [7:0] instr;
    logic       halt_req;
    logic       ir_we, pc_we, rf_we, reg_dst, alu_src, mem_re, mem_we, mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic       instr_done;
    logic [7:0] retired;
    logic       halted;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_W(2), .CNT_W(8)) dut (
        .clk        (clk),
        .Reset      (reset),
        .step_en    (step_en),
        .instr      (instr),
        .halt_req   (halt_req),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .rf_we      (rf_we),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .instr_done (instr_done),
        .retired    (retired),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_ir;
        int cnt_rf;
        logic [2:0] prev;
        logic [2:0] seq [4];
        seq = '{3'd1, 3'd2, 3'd4, 3'd0};

        reset = 1'b1; step_en = 1'b1; instr = 8'b00_01_10_11; halt_req = 1'b0;
        tick();
        chk("rst_ir_we", ir_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_state", state, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        tick();

        // ADD: 0,1,2,4,0
        reset = 1'b0; #1;
        chk("add_f_state", state, 0);
        chk("add_f_ir_we", ir_we, 1);
        chk("add_f_pc_we", pc_we, 1);
        chk("add_f_pc_src", pc_src, 0);
        chk("add_f_done", instr_done, 0);
        tick();
        chk("add_d_state", state, 1);
        chk("add_d_pc_we", pc_we, 0);
        chk("add_d_rf_we", rf_we, 0);
        tick();
        chk("add_e_state", state, 2);
        chk("add_e_alu_src", alu_src, 0);
        chk("add_e_rf_we", rf_we, 0);
        chk("add_e_done", instr_done, 0);
        tick();
        chk("add_w_state", state, 4);
        chk("add_w_rf_we", rf_we, 1);
        chk("add_w_reg_dst", reg_dst, 1);
        chk("add_w_m2r", mem_to_reg, 0);
        chk("add_w_done", instr_done, 1);
        instr = 8'h40;
        tick();
        chk("add_end_state", state, 0);
        chk("add_end_done", instr_done, 0);
        chk("add_retired", retired, 1);

        // LW: 0,1,2,3,4
        tick();
        chk("lw_d_state", state, 1);
        tick();
        chk("lw_e_state", state, 2);
        chk("lw_e_alu_src", alu_src, 1);
        tick();
        chk("lw_m_state", state, 3);
        chk("lw_m_mem_re", mem_re, 1);
        chk("lw_m_alu_src", alu_src, 1);
        chk("lw_m_rf_we", rf_we, 0);
        chk("lw_m_mem_we", mem_we, 0);
        tick();
        chk("lw_w_state", state, 4);
        chk("lw_w_mem_re", mem_re, 1);
        chk("lw_w_m2r", mem_to_reg, 1);
        chk("lw_w_rf_we", rf_we, 1);
        chk("lw_w_reg_dst", reg_dst, 0);
        instr = 8'h80;
        tick();
        chk("lw_retired", retired, 2);

        // SW: 0,1,2,3,0
        chk("sw_f_state", state, 0);
        tick();
        chk("sw_d_rf_we", rf_we, 0);
        tick();
        chk("sw_e_alu_src", alu_src, 1);
        chk("sw_e_mem_we", mem_we, 0);
        tick();
        chk("sw_m_state", state, 3);
        chk("sw_m_mem_we", mem_we, 1);
        chk("sw_m_mem_re", mem_re, 0);
        chk("sw_m_rf_we", rf_we, 0);
        chk("sw_m_done", instr_done, 1);
        instr = 8'hC5;
        tick();
        chk("sw_end_state", state, 0);
        chk("sw_end_mem_we", mem_we, 0);
        chk("sw_retired", retired, 3);

        // JMP: 2 steps
        chk("jmp_f_pc_we", pc_we, 1);
        chk("jmp_f_pc_src", pc_src, 0);
        tick();
        chk("jmp_d_state", state, 1);
        chk("jmp_d_pc_we", pc_we, 1);
        chk("jmp_d_pc_src", pc_src, 1);
        chk("jmp_d_done", instr_done, 1);
        instr = 8'b00_01_10_11;
        tick();
        chk("jmp_end_state", state, 0);
        chk("jmp_retired", retired, 4);

        // Stalled ADD, one step pulse every 4 clocks
        cnt_ir = 0;
        cnt_rf = 0;
        for (int k = 0; k < 16; k++) begin
            step_en = (k % 4 == 3);
            #1;
            if (ir_we) cnt_ir++;
            if (rf_we) cnt_rf++;
            prev = state;
            tick();
            if (k % 4 != 3) chk("stall_hold", state, prev);
            else            chk("stall_step", state, seq[k / 4]);
        end
        chk("stall_ir_cnt", cnt_ir, 1);
        chk("stall_rf_cnt", cnt_rf, 1);
        chk("stall_retired", retired, 5);

        // Reset during the MEM step of SW
        step_en = 1'b1; instr = 8'h80;
        tick(); tick(); tick();
        chk("rmid_state", state, 3);
        reset = 1'b1; #1;
        chk("rmid_mem_we", mem_we, 0);
        chk("rmid_done", instr_done, 0);
        tick();
        reset = 1'b0; step_en = 1'b0; #1;
        chk("rmid_state0", state, 0);
        chk("rmid_retired", retired, 0);

        // Halt requested during EXEC of ADD
        step_en = 1'b1; instr = 8'b00_01_10_11;
        tick(); tick();
        chk("halt_e_state", state, 2);
        halt_req = 1'b1;
        tick();
        chk("halt_w_state", state, 4);
        chk("halt_w_halted", halted, 0);
        tick();
        chk("halt_state", state, 5);
        chk("halt_halted", halted, 1);
        chk("halt_ir_we", ir_we, 0);
        chk("halt_pc_we", pc_we, 0);
        chk("halt_retired", retired, 1);
        tick();
        chk("halt_hold", state, 5);
        halt_req = 1'b0;
        tick();
        chk("unhalt_state", state, 0);
        chk("unhalt_halted", halted, 0);

        // Halt requested in FETCH is taken only after JMP retires
        instr = 8'hC5; halt_req = 1'b1;
        tick();
        chk("fhalt_d_state", state, 1);
        chk("fhalt_d_halted", halted, 0);
        tick();
        chk("fhalt_state", state, 5);
        chk("fhalt_retired", retired, 2);
        halt_req = 1'b0;
        tick();
        chk("fhalt_release", state, 0);

        // Counter wrap over 256 JMPs
        reset = 1'b1;
        tick();
        reset = 1'b0; instr = 8'hC5; step_en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            tick();
        end
        chk("wrap_255", retired, 255);
        tick();
        tick();
        chk("wrap_0", retired, 0);
        chk("wrap_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
